// File: rtl/sdp_rd_streamer.sv
// rtl/sdp_rd_streamer.sv - read-side streaming master for the sdp_two_clk RAM read port
//
// Sweeps len consecutive RAM addresses starting at base_addr and streams the
// read words, in order, on a valid/ready interface. All logic is in the clkb
// domain. A 4-entry output FIFO plus credit-based read issue absorbs the
// two-cycle read-to-capture latency, so no word is lost under backpressure
// and a continuously ready consumer sees one word per cycle.
//
// Ports:
//   clkb      - clock, shared with the RAM read port
//   rstb_n    - asynchronous active-low reset
//   start     - begin a sweep (sampled only while idle)
//   base_addr - first RAM address of the sweep
//   len       - number of words, 0..2^AW
//   busy      - sweep in progress (RUN or DRAIN)
//   done      - one-cycle pulse at sweep end
//   reb       - RAM read enable (registered)
//   addrb     - RAM read address (registered)
//   doutb     - RAM read data, valid the cycle after the RAM samples reb=1
//   m_valid   - stream data valid
//   m_data    - stream data (FIFO head)
//   m_ready   - stream consumer ready

module sdp_rd_streamer #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clkb,
  input  logic          rstb_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          reb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] doutb,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
);

  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [AW:0]   REM_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] addr_cnt;
  logic [AW:0]   remaining;
  logic          issue;
  logic [AW-1:0] issue_addr;
  logic [AW:0]   issue_rem;

  // vld_s1: read presented to the RAM this cycle; vld_s2: its data is on doutb
  logic          vld_s1;
  logic          vld_s2;
  logic [1:0]    pending;

  logic [DW-1:0] buf_mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;
  logic [3:0]    inflight;
  logic          push;
  logic          pop;

  assign pending  = {1'b0, vld_s1} + {1'b0, vld_s2};
  assign inflight = {1'b0, count} + {2'b00, pending};
  assign push     = vld_s2;
  assign m_valid  = (count != 3'd0);
  assign pop      = m_valid && m_ready;
  assign m_data   = buf_mem[rd_ptr];
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_FIN);

  // The first read is issued on the start edge itself, straight from the
  // start inputs, so the address counter only has to hold what comes after.
  assign issue_addr = (state == S_IDLE) ? base_addr : addr_cnt;
  assign issue_rem  = (state == S_IDLE) ? len : remaining;

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_RUN;
            issue     = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Occupancy is taken before this cycle's pop: conservative, and the
        // two-deep pipeline still keeps one read per cycle flowing.
        if ((remaining != '0) && (inflight < 4'd4)) begin
          issue = 1'b1;
        end
        if ((remaining == '0) || (issue && (remaining == REM_ONE))) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // With nothing pending there is no push, so the buffer is empty after
        // this edge if it is empty now or its last word is being accepted.
        if ((pending == 2'd0) && ((count == 3'd0) || ((count == 3'd1) && pop))) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      reb       <= 1'b0;
      addrb     <= '0;
      addr_cnt  <= '0;
      remaining <= '0;
    end else if (issue) begin
      reb       <= 1'b1;
      addrb     <= issue_addr;
      addr_cnt  <= issue_addr + ADDR_ONE;
      remaining <= issue_rem - REM_ONE;
    end else begin
      reb       <= 1'b0;
    end
  end

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      vld_s1 <= 1'b0;
      vld_s2 <= 1'b0;
    end else begin
      vld_s1 <= issue;
      vld_s2 <= vld_s1;
    end
  end

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      for (int i = 0; i < 4; i++) begin
        buf_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= doutb;
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/sdp_rd_streamer.md
# sdp_rd_streamer

Read-side master for the `sdp_two_clk` simple dual-port RAM. It lives entirely in the read-port (`clkb`) domain. On a `start` pulse it sweeps `len` consecutive addresses from `base_addr` through the RAM read port (`reb`/`addrb`/`doutb`) and delivers the words, in order, on a valid/ready stream. A 4-entry output buffer with credit-based read issue absorbs the RAM read latency, so no word is lost under backpressure and throughput is 1 word/cycle when `m_ready` is held high.

## Interface
- `AW`, 4, RAM address width
- `DW`, 4, RAM data width
- `clkb` input 1: clock, shared with the RAM read port
- `rstb_n` input 1: asynchronous active-low reset
- `start` input 1: begin a sweep; sampled only in IDLE
- `base_addr` input AW: first address, captured at start
- `len` input AW+1: word count, 0..2^AW, captured at start
- `busy` output 1: sweep in progress
- `done` output 1: one-cycle pulse at sweep end
- `reb` output 1: RAM read enable, registered
- `addrb` output AW: RAM read address, registered
- `doutb` input DW: RAM read data, valid the cycle after the RAM samples `reb`=1
- `m_valid` output 1: stream data valid
- `m_data` output DW: stream data (buffer head)
- `m_ready` input 1: stream consumer ready

## Operation
- FSM states:
  - IDLE: `start`=1 → RUN, or → FIN if `len`=0.
  - RUN: last read issued → DRAIN.
  - DRAIN: buffer empty and pending=0 → FIN.
  - FIN: → IDLE unconditionally.
- Capture at start: `addr_cnt`=`base_addr`, `remaining`=`len`.
- Read issue, evaluated each cycle in RUN: issue iff `remaining`>0 and `count`+`pending`<4.
  - `count` is buffer occupancy 0..4, taken before this cycle's pop.
  - `pending` is reads issued but not yet captured, 0..2.
  - Ignoring the same-cycle pop is deliberate: it keeps the check conservative, and full throughput is still reached.
- On issue, next cycle: `reb`=1, `addrb`=`addr_cnt`. `addr_cnt` increments modulo 2^AW (wraps 15→0 at AW=4). `remaining` decrements.
- No issue: `reb`=0 next cycle; `addrb` holds its last value.
- Capture: `doutb` is written into the buffer on the edge two cycles after the issue decision, tracked by a 2-stage valid shift register.
- Buffer is a 4-entry FIFO.
  - `m_valid`=(`count`>0), `m_data`=head entry.
  - Pop when `m_valid`&&`m_ready`.
  - Push and pop in the same cycle are legal; `count` is then unchanged.
- `m_data` holds stable while `m_valid`=1 and `m_ready`=0.
- `busy`=1 in RUN and DRAIN. `done`=1 only in FIN.
- `start` in RUN, DRAIN or FIN is ignored, with no effect on the running sweep.
- `len`=2^AW reads every address exactly once, wrapping from `base_addr`.
- Reset (any time, including mid-sweep) returns all state to idle values. Buffer contents and in-flight reads are discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `reb`=0, `addrb`=0, `m_valid`=0, `m_data`=0; FSM in IDLE, `count`=0, `pending`=0.
- Let E0 be the edge that samples `start`=1 in IDLE.
  - After E0: `busy`=1, `reb`=1, `addrb`=`base_addr`.
  - The RAM samples the read at E1; `doutb` is valid after E1.
  - The word is captured at E2; `m_valid`=1 after E2.
- Start-to-first-word latency: 2 cycles.
- With `m_ready`=1 throughout, reads issue on consecutive cycles and `m_valid` stays high for `len` consecutive cycles.
- Let En be the edge where the last word is accepted.
  - After En: FIN, so `busy`=0 and `done`=1 for one cycle.
  - After En+1: IDLE; a new `start` can be sampled at En+1.
- `len`=0: after E0, FIN (`done`=1, `busy`=0, no `reb`); IDLE one cycle later.

## Test plan
- Preload `mem[i]`=15−i. Start with `base_addr`=0, `len`=8, `m_ready`=1 → `reb` high 8 consecutive cycles; `m_data`=15,14,…,8 on consecutive cycles from E2; `done` one cycle after the 8th accept.
- `base_addr`=14, `len`=4 → `addrb`=14,15,0,1; data 1,0,15,14.
- `len`=8, `m_ready`=0 for the first 10 cycles → `reb` stops after 4 reads (buffer full); `m_data`=15 held; no loss. Then `m_ready`=1 → all 8 words in order.
- `m_ready` toggling 1010… for `len`=16 → 16 words 15..0 in order; `pending`≤2, `count`≤4 throughout.
- `len`=0 → `done` pulse one cycle after start, no `reb`, `m_valid` stays 0. A second `start` while `busy` → ignored, exactly `len` words delivered.
- Assert `rstb_n`=0 mid-sweep after 3 words → all outputs return to reset values immediately. A new sweep from 0 with `len`=2 → data 15,14 only, no stale words.
